// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the instruction-queue entry layout.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSN_NOP         = 32'h0000_0013;   // addi x0, x0, 0
    localparam logic [31:0] PC_STEP          = 32'd4;

    // One queued instruction: the fetch address travels with its word so
    // decode never has to reconstruct the PC.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } ifq_entry_t;

    localparam int ENTRY_W = $bits(ifq_entry_t);

    // Fetch addresses are word aligned; the low two bits are simply dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer holding {pc, ins} entries for the fetch queue.
// Latency: a word pushed in cycle N is visible on head_o in cycle N+1.
// Backpressure: none internally; the caller's credit rule prevents overflow.
//
// Ports:
//   clk, rstd          clock, asynchronous active-low reset
//   flush_i            empty the queue (wins over push/pop)
//   push_i/push_dat_i  write one entry at the tail
//   pop_i              retire the head entry (ignored when empty)
//   head_o             head entry, undefined content when count_o == 0
//   count_o            number of valid entries, 0..DEPTH
module ifq_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rstd,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_dat_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic [CNT_W-1:0]   count_o
);

    ifq_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Guards keep the pointers coherent even if a caller misbehaves.
    assign do_push = push_i && (count_q != CNT_W'(DEPTH)) && !flush_i;
    assign do_pop  = pop_i  && (count_q != '0)            && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= ifq_entry_t'(push_dat_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues word fetches, buffers in-order returns, hands them to decode.
// Latency: response in cycle N reaches the head in cycle N+1 (no bypass); redirect refetches in N+1.
// Backpressure: requests stop when queued + in-flight words reach DEPTH; responses are never stalled.
//
// Ports:
//   clk, rstd                         clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr      fetch request channel to instruction memory
//   rsp_valid/rsp_data                in-order instruction words from memory
//   ins_valid/ins_ready/ins/ins_pc    head of queue towards decode
//   redirect/redirect_pc              flush and restart fetch at a new address
module ifetch_queue
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rstd,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      req_addr_q, req_addr_d;
    logic [31:0]      rsp_pc_q,   rsp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_q,  discard_d;

    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     credit_used;
    logic [ENTRY_W-1:0] head_raw;
    ifq_entry_t         head;
    ifq_entry_t         push_entry;
    logic               req_fire;
    logic               rsp_take;
    logic               rsp_keep;
    logic               pop;
    logic [31:0]        target_pc;

    assign target_pc = align_pc(redirect_pc);

    // Every word is either queued or still owed by memory; both hold a slot.
    // Words destined to be discarded also hold credit until they return,
    // which is conservative but keeps overflow structurally impossible.
    assign credit_used = {1'b0, count} + {1'b0, inflight_q};

    // rstd gates the request so nothing is offered while reset is held,
    // yet the first request is already up before the first post-reset edge.
    assign req_valid = rstd && !redirect && (credit_used < (CNT_W+1)'(DEPTH));
    assign req_addr  = req_addr_q;
    assign req_fire  = req_valid && req_ready;

    // A response with nothing outstanding is spurious and ignored.
    assign rsp_take = rsp_valid && (inflight_q != '0);
    assign rsp_keep = rsp_take && (discard_q == '0) && !redirect;

    assign ins_valid = (count != '0);
    assign pop       = ins_valid && ins_ready && !redirect;

    assign push_entry.pc  = rsp_pc_q;
    assign push_entry.ins = rsp_data;

    always_comb begin
        req_addr_d = req_addr_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;

        case ({req_fire, rsp_take})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        if (redirect) begin
            req_addr_d = target_pc;
            rsp_pc_d   = target_pc;
            // Everything still owed by memory is stale, including words
            // already marked for discard, so the count is simply reloaded.
            discard_d  = rsp_take ? (inflight_q - CNT_W'(1)) : inflight_q;
        end else begin
            if (req_fire) begin
                req_addr_d = req_addr_q + PC_STEP;
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end
            if (rsp_take && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            req_addr_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            req_addr_q <= req_addr_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstd       (rstd),
        .flush_i    (redirect),
        .push_i     (rsp_keep),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .head_o     (head_raw),
        .count_o    (count)
    );

    assign head = ifq_entry_t'(head_raw);

    // An empty queue presents a NOP at the next expected PC, which after
    // reset is RESET_PC.
    assign ins    = ins_valid ? head.ins : INSN_NOP;
    assign ins_pc = ins_valid ? head.pc  : rsp_pc_q;

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rstd = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rstd        (rstd),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // One cycle of stimulus plus the outputs expected before its closing edge.
    typedef struct {
        bit          rst;     // pulse reset before this cycle
        int          lat;     // memory latency used after that reset
        bit          rr;
        bit          ir;
        bit          rd;
        logic [31:0] rpc;
        bit          erv;
        logic [31:0] era;
        bit          eiv;
        logic [31:0] eipc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    vec_t  vecs[$];
    pend_t pend[$];
    int    cyc;
    int    lat;
    int    total;
    int    bad;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input bit rst, input int l, input bit rr, input bit ir, input bit rd,
                       input logic [31:0] rpc, input bit erv, input logic [31:0] era,
                       input bit eiv, input logic [31:0] eipc);
        vec_t v;
        v.rst = rst; v.lat = l; v.rr = rr; v.ir = ir; v.rd = rd; v.rpc = rpc;
        v.erv = erv; v.era = era; v.eiv = eiv; v.eipc = eipc;
        vecs.push_back(v);
    endtask

    // Reset is released one time unit after a posedge; the next posedge
    // closes cycle 0.
    task automatic do_reset(input int l);
        rstd = 1'b0;
        req_ready = 1'b0; ins_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rsp_valid = 1'b0; rsp_data = '0;
        pend.delete();
        lat = l;
        @(posedge clk); #1;
        rstd = 1'b1;
        cyc = 0;
    endtask

    task automatic step(input vec_t v);
        pend_t p;
        if (v.rst) do_reset(v.lat);
        rsp_valid = 1'b0;
        rsp_data  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = word_of(pend[0].addr);
            void'(pend.pop_front());
        end
        req_ready   = v.rr;
        ins_ready   = v.ir;
        redirect    = v.rd;
        redirect_pc = v.rpc;
        #1;
        check("req_valid", {31'b0, req_valid}, {31'b0, v.erv});
        check("req_addr",  req_addr, v.era);
        check("ins_valid", {31'b0, ins_valid}, {31'b0, v.eiv});
        if (v.eiv) begin
            check("ins_pc", ins_pc, v.eipc);
            check("ins",    ins,    word_of(v.eipc));
        end
        if (req_valid && req_ready) begin
            p.addr = req_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        lat   = 1;

        // Streaming: 1-cycle memory, decode always ready.
        add(1,1, 1,1,0,0, 1,32'd0,0,0);
        add(0,1, 1,1,0,0, 1,32'd4,0,0);
        for (int k = 2; k < 8; k++) add(0,1, 1,1,0,0, 1,32'(4*k),1,32'(4*(k-2)));

        // Decode stalled 10 cycles: four words fill the queue, then drain.
        add(1,1, 1,0,0,0, 1,32'd0,0,0);
        add(0,1, 1,0,0,0, 1,32'd4,0,0);
        add(0,1, 1,0,0,0, 1,32'd8,1,32'd0);
        add(0,1, 1,0,0,0, 1,32'd12,1,32'd0);
        for (int k = 4; k < 10; k++) add(0,1, 1,0,0,0, 0,32'd16,1,32'd0);
        add(0,1, 1,1,0,0, 0,32'd16,1,32'd0);
        add(0,1, 1,1,0,0, 1,32'd16,1,32'd4);
        add(0,1, 1,1,0,0, 1,32'd20,1,32'd8);
        add(0,1, 1,1,0,0, 1,32'd24,1,32'd12);
        add(0,1, 1,1,0,0, 1,32'd28,1,32'd16);

        // Memory stall with req_addr=8: request and head held steady.
        add(1,1, 1,1,0,0, 1,32'd0,0,0);
        add(0,1, 1,1,0,0, 1,32'd4,0,0);
        for (int k = 2; k < 7; k++) add(0,1, 0,0,0,0, 1,32'd8,1,32'd0);
        add(0,1, 1,1,0,0, 1,32'd8,1,32'd0);
        add(0,1, 1,1,0,0, 1,32'd12,1,32'd4);
        add(0,1, 1,1,0,0, 1,32'd16,1,32'd8);

        // 3-cycle memory, redirect to 0x103 with 20/24/28 outstanding.
        add(1,3, 1,1,0,0, 1,32'd0,0,0);
        add(0,3, 1,1,0,0, 1,32'd4,0,0);
        add(0,3, 1,1,0,0, 1,32'd8,0,0);
        add(0,3, 1,1,0,0, 1,32'd12,0,0);
        add(0,3, 1,1,0,0, 0,32'd16,1,32'd0);
        add(0,3, 1,1,0,0, 1,32'd16,1,32'd4);
        add(0,3, 1,1,0,0, 1,32'd20,1,32'd8);
        add(0,3, 1,1,0,0, 1,32'd24,1,32'd12);
        add(0,3, 1,1,0,0, 1,32'd28,0,0);
        add(0,3, 1,1,1,32'h103, 0,32'd32,1,32'd16);
        add(0,3, 1,1,0,0, 1,32'h100,0,0);
        add(0,3, 1,1,0,0, 1,32'h104,0,0);
        add(0,3, 1,1,0,0, 1,32'h108,0,0);
        add(0,3, 1,1,0,0, 1,32'h10C,0,0);
        add(0,3, 1,1,0,0, 0,32'h110,1,32'h100);
        add(0,3, 1,1,0,0, 1,32'h110,1,32'h104);

        // Redirect coinciding with a response and a pop, count=2.
        add(1,1, 1,0,0,0, 1,32'd0,0,0);
        add(0,1, 1,0,0,0, 1,32'd4,0,0);
        add(0,1, 1,0,0,0, 1,32'd8,1,32'd0);
        add(0,1, 1,1,1,32'h40, 0,32'd12,1,32'd0);
        add(0,1, 1,1,0,0, 1,32'h40,0,0);
        add(0,1, 1,1,0,0, 1,32'h44,0,0);
        add(0,1, 1,1,0,0, 1,32'h48,1,32'h40);

        // Outputs while reset is held from time zero.
        #1;
        check("rst_req_valid", {31'b0, req_valid}, 32'd0);
        check("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
        check("rst_req_addr",  req_addr, 32'h0);
        check("rst_ins",       ins,      32'h13);
        check("rst_ins_pc",    ins_pc,   32'h0);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Mid-stream reset with count=3, inflight=1: outputs drop at once.
        vecs.delete();
        add(1,1, 1,0,0,0, 1,32'd0,0,0);
        add(0,1, 1,0,0,0, 1,32'd4,0,0);
        add(0,1, 1,0,0,0, 1,32'd8,1,32'd0);
        add(0,1, 1,0,0,0, 1,32'd12,1,32'd0);
        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
        check("pre_mid_ins_valid", {31'b0, ins_valid}, 32'd1);
        check("pre_mid_req_addr",  req_addr, 32'd16);
        #2;
        rstd = 1'b0;
        #1;
        check("mid_rst_req_valid", {31'b0, req_valid}, 32'd0);
        check("mid_rst_ins_valid", {31'b0, ins_valid}, 32'd0);
        check("mid_rst_req_addr",  req_addr, 32'h0);
        check("mid_rst_ins",       ins,      32'h13);
        check("mid_rst_ins_pc",    ins_pc,   32'h0);
        // A response during reset must not land in the queue.
        rsp_valid = 1'b1;
        rsp_data  = word_of(32'd12);
        @(posedge clk); #1;
        check("rst_rsp_ignored", {31'b0, ins_valid}, 32'd0);

        vecs.delete();
        add(1,1, 1,1,0,0, 1,32'd0,0,0);
        add(0,1, 1,1,0,0, 1,32'd4,0,0);
        add(0,1, 1,1,0,0, 1,32'd8,1,32'd0);
        add(0,1, 1,1,0,0, 1,32'd12,1,32'd4);
        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
